// File: rtl/fifo_arb_pkg.sv
// Shared state encoding, default parameters and round-robin helper for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      StIdle  = 1'b0,
      StBurst = 1'b1
   } arb_state_e;

   localparam int unsigned DefNSrc     = 4;
   localparam int unsigned DefDw       = 8;
   localparam int unsigned DefMaxBurst = 16;
   localparam int unsigned MaxSrc      = 8;

   // First set bit of req searching upward from last+1, wrapping at n.
   function automatic int unsigned rr_pick(input logic [MaxSrc-1:0] req,
                                           input int unsigned n,
                                           input int unsigned last);
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MaxSrc; k++) begin
         int unsigned c;
         c = (last + k) % n;
         if (k <= n && !found && req[3'(c)]) begin
            idx   = c;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals shared by the arbiter; master is the
// arbiter view, slave the producer/FIFO view.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_SRC = DefNSrc,
   parameter int unsigned DW    = DefDw
);
   logic [N_SRC-1:0]    src_req;
   logic [N_SRC*DW-1:0] src_data;
   logic [N_SRC-1:0]    src_ack;
   logic                wreqa;
   logic [DW-1:0]       wdata;
   logic                fulla;

   modport master (
      input  src_req, src_data, fulla,
      output src_ack, wreqa, wdata
   );

   modport slave (
      output src_req, src_data, fulla,
      input  src_ack, wreqa, wdata
   );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: next requester after last, with wrap.
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned  N_SRC = DefNSrc,
   localparam int unsigned OW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic [N_SRC-1:0] req,
   input  logic [OW-1:0]    last,
   output logic [OW-1:0]    idx,
   output logic             valid
);
   logic [MaxSrc-1:0] req_ext;
   int unsigned       pick;

   always_comb begin
      req_ext             = '0;
      req_ext[N_SRC-1:0]  = req;
      pick                = rr_pick(req_ext, N_SRC, 32'(last));
      idx                 = OW'(pick);
      valid               = |req;
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// Optional saturating wr_count/stall_count outputs under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned  N_SRC     = DefNSrc,
   parameter int unsigned  DW        = DefDw,
   parameter int unsigned  MAX_BURST = DefMaxBurst,
   localparam int unsigned OW        = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int unsigned BW        = $clog2(MAX_BURST + 1)
) (
   input  logic                     clka,
   input  logic                     rsta,
   fifo_wr_arbiter_if.master        bus,
   output logic                     busy,
   output logic [OW-1:0]            owner
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]              wr_count,
   output logic [15:0]              stall_count
`endif
);
   arb_state_e    state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [OW-1:0] pick_idx;
   logic          pick_valid;
   logic          own_req;
   logic          wr;

   fifo_rr_pick #(
      .N_SRC (N_SRC)
   ) u_pick (
      .req   (bus.src_req),
      .last  (last_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign own_req = bus.src_req[owner_q];
   assign wr      = (state_q == StBurst) && own_req && !bus.fulla;

   always_comb begin
      bus.wreqa   = wr;
      bus.wdata   = (state_q == StBurst) ? bus.src_data[owner_q*DW +: DW] : '0;
      bus.src_ack = '0;
      if (wr) begin
         bus.src_ack[owner_q] = 1'b1;
      end
      busy  = (state_q == StBurst);
      owner = owner_q;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               bcnt_d  = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            // A run-dry owner ends the burst; a full stall alone never does.
            if (!own_req) begin
               state_d = StIdle;
               last_d  = owner_q;
            end else if (wr) begin
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == BW'(MAX_BURST - 1)) begin
                  state_d = StIdle;
                  last_d  = owner_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= OW'(N_SRC - 1);
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         bcnt_q  <= bcnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] stall_cnt_q;
   logic        stall;

   assign stall = (state_q == StBurst) && own_req && bus.fulla;

   always_ff @(posedge clka) begin
      if (rsta) begin
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign wr_count    = wr_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule
